// File: rtl/kv_cache_lru.sv
// Key/value lookup cache: insertion-order eviction, in-place update, multi-cycle flush FSM.
// Optional hit/miss statistics counters are built when KV_CACHE_STATS_EN is defined.
module kv_cache_lru #(
    parameter int unsigned WORDS = 8,
    parameter int unsigned KEY_W = 8,
    parameter int unsigned VAL_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       lk_valid_i,
    output logic                       lk_ready_o,
    input  logic [KEY_W-1:0]           lk_key_i,
    output logic                       rs_valid_o,
    output logic                       rs_hit_o,
    output logic [VAL_W-1:0]           rs_value_o,
    input  logic                       up_valid_i,
    output logic                       up_ready_o,
    input  logic [KEY_W-1:0]           up_key_i,
    input  logic [VAL_W-1:0]           up_value_i,
    output logic                       ev_valid_o,
    output logic [KEY_W-1:0]           ev_key_o,
    input  logic                       flush_i,
    output logic                       flush_done_o,
`ifdef KV_CACHE_STATS_EN
    output logic [CNT_W-1:0]           hit_count_o,
    output logic [CNT_W-1:0]           miss_count_o,
`endif
    output logic [$clog2(WORDS+1)-1:0] occupancy_o
);

    localparam int unsigned IdxW = $clog2(WORDS);
    localparam int unsigned OccW = $clog2(WORDS+1);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic               ready_q, ready_d;
    logic [WORDS-1:0]   valid_q, valid_d;
    logic [KEY_W-1:0]   key_q [WORDS];
    logic [KEY_W-1:0]   key_d [WORDS];
    logic [VAL_W-1:0]   val_q [WORDS];
    logic [VAL_W-1:0]   val_d [WORDS];
    logic [OccW-1:0]    occ_q, occ_d;
    logic               rs_valid_q, rs_valid_d;
    logic               rs_hit_q, rs_hit_d;
    logic [VAL_W-1:0]   rs_value_q, rs_value_d;
    logic               ev_valid_q, ev_valid_d;
    logic [KEY_W-1:0]   ev_key_q, ev_key_d;

    logic               lk_acc, up_acc, flush_done;
    logic               lk_hit, up_hit;
    logic [VAL_W-1:0]   lk_val;
    logic [IdxW-1:0]    up_idx;

    assign lk_acc = lk_valid_i & ready_q;
    assign up_acc = up_valid_i & ready_q;

    // Search from oldest to newest so the lowest matching index wins.
    always_comb begin
        lk_hit = 1'b0;
        lk_val = '0;
        up_hit = 1'b0;
        up_idx = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (valid_q[i] && key_q[i] == lk_key_i) begin
                lk_hit = 1'b1;
                lk_val = val_q[i];
            end
            if (valid_q[i] && key_q[i] == up_key_i) begin
                up_hit = 1'b1;
                up_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        key_d      = key_q;
        val_d      = val_q;
        occ_d      = occ_q;
        flush_done = 1'b0;
        rs_valid_d = lk_acc;
        rs_hit_d   = lk_acc & lk_hit;
        rs_value_d = lk_acc ? lk_val : '0;
        ev_valid_d = 1'b0;
        ev_key_d   = '0;

        if (up_acc) begin
            if (up_hit) begin
                val_d[up_idx] = up_value_i;
            end else begin
                for (int i = WORDS - 1; i > 0; i--) begin
                    valid_d[i] = valid_q[i-1];
                    key_d[i]   = key_q[i-1];
                    val_d[i]   = val_q[i-1];
                end
                valid_d[0] = 1'b1;
                key_d[0]   = up_key_i;
                val_d[0]   = up_value_i;
                ev_valid_d = valid_q[WORDS-1];
                ev_key_d   = valid_q[WORDS-1] ? key_q[WORDS-1] : '0;
                if (occ_q != OccW'(WORDS)) begin
                    occ_d = occ_q + OccW'(1);
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    state_d = StFlush;
                    idx_d   = '0;
                end
            end
            StFlush: begin
                valid_d[idx_q] = 1'b0;
                idx_d          = idx_q + IdxW'(1);
                if (idx_q == IdxW'(WORDS - 1)) begin
                    state_d    = StIdle;
                    idx_d      = '0;
                    occ_d      = '0;
                    flush_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            ready_q    <= 1'b0;
            valid_q    <= '0;
            occ_q      <= '0;
            rs_valid_q <= 1'b0;
            rs_hit_q   <= 1'b0;
            rs_value_q <= '0;
            ev_valid_q <= 1'b0;
            ev_key_q   <= '0;
            for (int i = 0; i < WORDS; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            occ_q      <= occ_d;
            rs_valid_q <= rs_valid_d;
            rs_hit_q   <= rs_hit_d;
            rs_value_q <= rs_value_d;
            ev_valid_q <= ev_valid_d;
            ev_key_q   <= ev_key_d;
            key_q      <= key_d;
            val_q      <= val_d;
        end
    end

`ifdef KV_CACHE_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (flush_done) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (lk_acc) begin
            if (lk_hit && hit_cnt_q != '1) begin
                hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
            if (!lk_hit && miss_cnt_q != '1) begin
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

    assign lk_ready_o   = ready_q;
    assign up_ready_o   = ready_q;
    assign rs_valid_o   = rs_valid_q;
    assign rs_hit_o     = rs_hit_q;
    assign rs_value_o   = rs_value_q;
    assign ev_valid_o   = ev_valid_q;
    assign ev_key_o     = ev_key_q;
    assign flush_done_o = flush_done;
    assign occupancy_o  = occ_q;

endmodule
